// File: rtl/dcache_assoc.sv
// N-way set-associative, write-back, write-allocate data cache with invalid-first /
// round-robin replacement, byte-enable stores and an explicit line-flush operation.
module dcache_assoc #(
    parameter int unsigned LINE_SIZE  = 32,
    parameter int unsigned CACHE_SIZE = 1024,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned XLEN       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN/8-1:0] req_be,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              hmem_valid,
    output logic              hmem_we,
    output logic [XLEN-1:0]   hmem_addr,
    output logic [XLEN-1:0]   hmem_wdata,
    input  logic              hmem_ready,
    input  logic [XLEN-1:0]   hmem_rdata
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned WORDS = LINE_SIZE * 8 / XLEN;
    localparam int unsigned SETS  = CACHE_SIZE / (LINE_SIZE * WAYS);
    localparam int unsigned OFF   = $clog2(LINE_SIZE);
    localparam int unsigned IDX   = $clog2(SETS);
    localparam int unsigned BOFF  = $clog2(BYTES);
    localparam int unsigned TAG_W = XLEN - OFF - IDX;
    localparam int unsigned CNT_W = OFF - BOFF;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned BE_W  = $clog2(BYTES);

    localparam logic [1:0] OpStore = 2'd1;
    localparam logic [1:0] OpFlush = 2'd2;

    typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StFill, StResp} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [BYTES-1:0]   be_q, be_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [WAYS-1:0]    dirty_d [SETS];
    logic [WAY_W-1:0]   rr_q [SETS];
    logic [WAY_W-1:0]   rr_d [SETS];
    logic               rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic               hmem_valid_q, hmem_valid_d;
    logic               hmem_we_q, hmem_we_d;
    logic [XLEN-1:0]    hmem_addr_q, hmem_addr_d;
    logic [XLEN-1:0]    hmem_wdata_q, hmem_wdata_d;

    // Data and tag storage carry no reset; the valid bits gate every use.
    logic [XLEN-1:0]    data_mem [SETS][WAYS][WORDS];
    logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];

    logic [IDX-1:0]     set_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [CNT_W-1:0]   word_idx;
    logic               hit, inv_found, last, st_we, fill_we;
    logic [WAY_W-1:0]   hit_way, inv_way, rr_next;
    logic               unused_addr;

    assign set_idx     = addr_q[OFF+IDX-1:OFF];
    assign req_tag     = addr_q[XLEN-1:OFF+IDX];
    assign word_idx    = addr_q[OFF-1:BOFF];
    assign last        = (cnt_q == CNT_W'(WORDS - 1));
    assign rr_next     = (victim_q == WAY_W'(WAYS - 1)) ? '0 : victim_q + WAY_W'(1);
    assign unused_addr = ^addr_q[BOFF-1:0];

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign hmem_valid = hmem_valid_q;
    assign hmem_we    = hmem_we_q;
    assign hmem_addr  = hmem_addr_q;
    assign hmem_wdata = hmem_wdata_q;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][WAY_W'(w)] && (tag_mem[set_idx][WAY_W'(w)] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_idx][WAY_W'(w)] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        victim_d    = victim_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        rr_d        = rr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        st_we       = 1'b0;
        fill_we     = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                cnt_d = '0;
                if (op_q == OpFlush) begin
                    if (hit && dirty_q[set_idx][hit_way]) begin
                        victim_d = hit_way;
                        state_d  = StWriteback;
                    end else begin
                        if (hit) valid_d[set_idx][hit_way] = 1'b0;
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                    end
                end else if (hit) begin
                    if (op_q == OpStore) begin
                        st_we = 1'b1;
                        if (|be_q) dirty_d[set_idx][hit_way] = 1'b1;
                    end else begin
                        rsp_rdata_d = data_mem[set_idx][hit_way][word_idx];
                    end
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                end else begin
                    victim_d = inv_found ? inv_way : rr_q[set_idx];
                    if (valid_q[set_idx][victim_d] && dirty_q[set_idx][victim_d]) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StWriteback: begin
                if (hmem_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last) begin
                        dirty_d[set_idx][victim_q] = 1'b0;
                        if (op_q == OpFlush) begin
                            valid_d[set_idx][victim_q] = 1'b0;
                            state_d     = StResp;
                            rsp_valid_d = 1'b1;
                        end else begin
                            state_d = StFill;
                        end
                    end
                end
            end
            StFill: begin
                if (hmem_ready) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last) begin
                        valid_d[set_idx][victim_q] = 1'b1;
                        dirty_d[set_idx][victim_q] = 1'b0;
                        rr_d[set_idx] = rr_next;
                        // Replay the lookup; the line is now resident so it hits.
                        state_d = StLookup;
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        hmem_valid_d = (state_d == StWriteback) || (state_d == StFill);
        hmem_we_d    = (state_d == StWriteback);
        hmem_addr_d  = '0;
        hmem_wdata_d = '0;
        if (state_d == StWriteback) begin
            hmem_addr_d  = {tag_mem[set_idx][victim_d], set_idx, cnt_d, {BOFF{1'b0}}};
            hmem_wdata_d = data_mem[set_idx][victim_d][cnt_d];
        end else if (state_d == StFill) begin
            hmem_addr_d = {req_tag, set_idx, cnt_d, {BOFF{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            victim_q     <= '0;
            cnt_q        <= '0;
            valid_q      <= '{default: '0};
            dirty_q      <= '{default: '0};
            rr_q         <= '{default: '0};
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            hmem_valid_q <= 1'b0;
            hmem_we_q    <= 1'b0;
            hmem_addr_q  <= '0;
            hmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            rr_q         <= rr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            hmem_valid_q <= hmem_valid_d;
            hmem_we_q    <= hmem_we_d;
            hmem_addr_q  <= hmem_addr_d;
            hmem_wdata_q <= hmem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (st_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be_q[BE_W'(b)]) begin
                    data_mem[set_idx][hit_way][word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
        if (fill_we) begin
            data_mem[set_idx][victim_q][cnt_q] <= hmem_rdata;
            if (last) tag_mem[set_idx][victim_q] <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_assoc.sv
// Randomised scoreboard bench for dcache_assoc: a line-residency model predicts response
// data and the exact next-level traffic of every request; a monitor checks on each response.
module tb_dcache_assoc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        hmem_valid, hmem_we;
    logic [31:0] hmem_addr, hmem_wdata;
    logic        hmem_ready;
    logic [31:0] hmem_rdata;

    dcache_assoc #(.LINE_SIZE(32), .CACHE_SIZE(1024), .WAYS(2), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .hmem_valid(hmem_valid), .hmem_we(hmem_we), .hmem_addr(hmem_addr),
        .hmem_wdata(hmem_wdata), .hmem_ready(hmem_ready), .hmem_rdata(hmem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Backing memory (seen by the DUT) and the architectural truth the core should observe.
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] bread(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rread(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // Residency model: which tag sits in which way of each of 16 sets.
    bit          m_valid [16][2];
    bit          m_dirty [16][2];
    logic [22:0] m_tag   [16][2];
    int          m_rr    [16];

    typedef struct {
        logic [31:0] rdata;
        int          n_wb;
        logic [31:0] wb_base;
        int          n_fill;
        logic [31:0] fill_base;
        int          acc;
    } exp_t;
    typedef struct {
        bit          we;
        logic [31:0] addr;
    } xfer_t;

    exp_t  exp_q[$];
    xfer_t obs_q[$];
    logic [31:0] last_rdata;

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, output exp_t e);
        int          s, hw, v;
        logic [22:0] t;
        logic [31:0] wa, base, cur;
        s  = int'(addr[8:5]);
        t  = addr[31:9];
        wa = {addr[31:2], 2'b00};
        base = {addr[31:5], 5'b0};
        e.rdata = '0; e.n_wb = 0; e.wb_base = '0; e.n_fill = 0; e.fill_base = '0; e.acc = 0;
        hw = -1;
        for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        if (op == 2'd2) begin
            if (hw >= 0) begin
                if (m_dirty[s][hw]) begin
                    e.n_wb = 8;
                    e.wb_base = base;
                end
                m_valid[s][hw] = 1'b0;
                m_dirty[s][hw] = 1'b0;
            end
        end else begin
            if (hw < 0) begin
                v = -1;
                for (int w = 0; w < 2; w++) if (!m_valid[s][w] && v < 0) v = w;
                if (v < 0) v = m_rr[s];
                if (m_valid[s][v] && m_dirty[s][v]) begin
                    e.n_wb = 8;
                    e.wb_base = {m_tag[s][v], addr[8:5], 5'b0};
                end
                e.n_fill = 8;
                e.fill_base = base;
                m_valid[s][v] = 1'b1;
                m_dirty[s][v] = 1'b0;
                m_tag[s][v]   = t;
                m_rr[s]       = (v + 1) % 2;
                hw = v;
            end
            if (op == 2'd1) begin
                cur = rread(wa);
                for (int b = 0; b < 4; b++) if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
                ref_mem[wa] = cur;
                if (be != 4'b0) m_dirty[s][hw] = 1'b1;
            end else begin
                e.rdata = rread(wa);
            end
        end
    endtask

    // Next-level memory: random or forced stalls, records every completed transfer.
    bit          rand_stall = 1'b0;
    int          stall_left = 0;
    bit          prev_stall = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;

    always @(negedge clk) begin
        if (prev_stall && rst_n) begin
            check("hold_valid", {31'b0, hmem_valid}, 32'd1);
            check("hold_we", {31'b0, hmem_we}, {31'b0, prev_we});
            check("hold_addr", hmem_addr, prev_addr);
            check("hold_wdata", hmem_wdata, prev_wdata);
        end
        if (!rst_n || !hmem_valid) begin
            hmem_ready = 1'b0;
        end else if (stall_left > 0 && hmem_we && hmem_addr[4:2] == 3'd2) begin
            hmem_ready = 1'b0;
            stall_left--;
        end else begin
            hmem_ready = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        hmem_rdata = $urandom;
        if (hmem_ready) begin
            if (hmem_we) bmem[hmem_addr] = hmem_wdata;
            else hmem_rdata = bread(hmem_addr);
            obs_q.push_back('{we: hmem_we, addr: hmem_addr});
        end
        prev_stall = rst_n && hmem_valid && !hmem_ready;
        prev_we    = hmem_we;
        prev_addr  = hmem_addr;
        prev_wdata = hmem_wdata;
    end

    // Response monitor / scoreboard.
    exp_t        me;
    int          nexp;
    logic [31:0] bad;
    bit          we_e;
    logic [31:0] a_e;

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            check("rsp_pending", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                me = exp_q.pop_front();
                last_rdata = rsp_rdata;
                check("rsp_rdata", rsp_rdata, me.rdata);
                nexp = me.n_wb + me.n_fill;
                check("traffic_count", obs_q.size(), nexp);
                bad = '1;
                for (int i = 0; i < obs_q.size() && i < nexp; i++) begin
                    we_e = (i < me.n_wb);
                    a_e  = we_e ? me.wb_base + 32'(4 * i) : me.fill_base + 32'(4 * (i - me.n_wb));
                    if ((obs_q[i].we != we_e || obs_q[i].addr !== a_e) && bad == '1) bad = i;
                end
                check("traffic_seq_first_bad", bad, 32'hFFFFFFFF);
                if (nexp == 0) check("hit_latency", cyc - me.acc, 32'd2);
            end
            obs_q.delete();
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        model(op, addr, wdata, be, e);
        e.acc = cyc;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !req_ready) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    logic [31:0] w44, expw;
    int          nreads;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_hmem_valid", {31'b0, hmem_valid}, 32'd0);
        check("rst_hmem_we", {31'b0, hmem_we}, 32'd0);
        check("rst_hmem_addr", hmem_addr, 32'd0);
        check("rst_hmem_wdata", hmem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Cold fill, hit, partial store.
        issue(2'd0, 32'h40, '0, '0);
        issue(2'd0, 32'h40, '0, '0);
        issue(2'd1, 32'h44, 32'hDEADBEEF, 4'b0011);
        issue(2'd0, 32'h44, '0, '0);
        wait_idle();
        w44  = init_word(32'h44);
        expw = {w44[31:16], 16'hBEEF};
        check("partial_store_word", last_rdata, expw);

        // Conflict eviction in set 0, then flushes.
        issue(2'd0, 32'h000, '0, '0);
        issue(2'd0, 32'h200, '0, '0);
        issue(2'd1, 32'h000, 32'h11223344, 4'hF);
        issue(2'd0, 32'h400, '0, '0);
        issue(2'd0, 32'h200, '0, '0);
        issue(2'd0, 32'h000, '0, '0);
        issue(2'd1, 32'h000, 32'hCAFEF00D, 4'hF);
        issue(2'd2, 32'h000, '0, '0);
        issue(2'd0, 32'h000, '0, '0);
        issue(2'd2, 32'h800, '0, '0);

        // Writeback stalled for 5 cycles on word 2.
        stall_left = 5;
        issue(2'd1, 32'h020, 32'h12345678, 4'hF);
        issue(2'd0, 32'h220, '0, '0);
        issue(2'd0, 32'h420, '0, '0);
        wait_idle();
        check("stall_consumed", stall_left, 32'd0);

        // Store with no byte enables allocates clean.
        issue(2'd1, 32'h060, 32'hFFFFFFFF, 4'b0000);
        issue(2'd2, 32'h060, '0, '0);

        // Random traffic over 4 sets x 4 tags with random hmem stalls.
        rand_stall = 1'b1;
        repeat (300) begin
            int          r;
            logic [1:0]  op;
            logic [31:0] a;
            r  = $urandom_range(0, 99);
            op = (r < 45) ? 2'd0 : (r < 80) ? 2'd1 : (r < 92) ? 2'd2 : 2'd3;
            a  = 32'($urandom_range(0, 3)) * 32'h200 + 32'($urandom_range(0, 3)) * 32'h20
               + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            issue(op, a, $urandom, 4'($urandom_range(0, 15)));
        end

        // Flush everything touched and compare backing memory with the truth.
        for (int tg = 0; tg < 5; tg++) begin
            for (int s = 0; s < 4; s++) issue(2'd2, 32'(tg * 32'h200 + s * 32'h20), '0, '0);
        end
        wait_idle();
        foreach (ref_mem[a]) check("coherence", bread(a), ref_mem[a]);

        // Reset in the middle of a fill.
        rand_stall = 1'b0;
        issue(2'd0, 32'h1000, '0, '0);
        nreads = 0;
        for (int i = 0; i < 100 && nreads < 4; i++) begin
            @(negedge clk);
            #1;
            nreads = 0;
            foreach (obs_q[k]) if (!obs_q[k].we) nreads++;
        end
        check("fill_progress", nreads, 32'd4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hmem_valid", {31'b0, hmem_valid}, 32'd0);
        check("mid_rst_hmem_addr", hmem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        model_reset();
        @(negedge clk);
        #1;
        check("post_mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        issue(2'd0, 32'h1000, '0, '0);
        issue(2'd0, 32'h1004, '0, '0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
